// File: rtl/da2_pkg.sv
// da2_pkg: shared frame constants, power-down codes and FSM encoding for the PmodDA2 transmitter
package da2_pkg;
  localparam int FRAME_W = 16;
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  function automatic logic [FRAME_W-1:0] frame_word(input logic [1:0] pd, input logic [11:0] d);
    return {2'b00, pd, d};
  endfunction
endpackage

// File: rtl/da2_bit_timer.sv
// da2_bit_timer: bit-period divider giving next-cycle SCLK phase and end-of-bit tick
module da2_bit_timer import da2_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clr,
  output logic phase_n,
  output logic bit_end
);
  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV);
  logic [CW-1:0] cnt, cnt_n;
  // cnt is the position inside the current bit period; phase_n is the SCLK level for the next cycle
  always_comb begin
    bit_end = cnt == LAST;
    cnt_n   = (clr || bit_end) ? '0 : cnt + 1'b1;
    phase_n = cnt_n < HALF;
  end
  // free-running divider, realigned to a fresh bit period whenever a frame is loaded
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) cnt <= '0;
    else cnt <= cnt_n;
endmodule

// File: rtl/da2_serial_tx.sv
// da2_serial_tx: dual-channel DAC121S101 frame shifter with a one-deep pending-start buffer
module da2_serial_tx import da2_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic [11:0] DATA1,
  input  logic [11:0] DATA2,
  input  logic [1:0]  PD,
  output logic        SCLK,
  output logic        nSYNC,
  output logic        D1,
  output logic        D2,
  output logic        BUSY,
  output logic        DONE
);
  state_t state, state_n;
  logic [3:0] bit_cnt;
  logic [FRAME_W-1:0] sh1, sh2;
  logic [11:0] hold1, hold2;
  logic [1:0] hold_pd;
  logic pend, load, use_in, done_n, phase_n, bit_end;
  da2_bit_timer #(.DIV(DIV)) u_timer (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clr    (load),
    .phase_n(phase_n),
    .bit_end(bit_end)
  );
  // next state: accept from the inputs in IDLE, from the holding register at the end of TAIL
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    load    = 1'b0;
    use_in  = START && state == IDLE;
    if (state == IDLE) load = START || pend;
    else if (state == SHIFT) state_n = (bit_end && bit_cnt == 4'd0) ? TAIL : SHIFT;
    else if (bit_end) begin
      done_n  = 1'b1;
      load    = pend;
      state_n = IDLE;
    end
    if (load) state_n = SHIFT;
  end
  // state register
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) state <= IDLE;
    else state <= state_n;
  // registered pins, shift registers and pending buffer; shifting in zeros leaves D low after bit 0
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      SCLK    <= 1'b1;
      nSYNC   <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      bit_cnt <= 4'd0;
      sh1     <= '0;
      sh2     <= '0;
      hold1   <= '0;
      hold2   <= '0;
      hold_pd <= PD_NORMAL;
      pend    <= 1'b0;
    end else begin
      SCLK  <= state_n != SHIFT || phase_n;
      nSYNC <= state_n != SHIFT;
      BUSY  <= state_n != IDLE && !done_n;
      DONE  <= done_n;
      if (load) begin
        sh1     <= use_in ? frame_word(PD, DATA1) : frame_word(hold_pd, hold1);
        sh2     <= use_in ? frame_word(PD, DATA2) : frame_word(hold_pd, hold2);
        bit_cnt <= 4'd15;
      end else if (state == SHIFT && bit_end) begin
        sh1     <= {sh1[FRAME_W-2:0], 1'b0};
        sh2     <= {sh2[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (START && state != IDLE) begin
        pend    <= 1'b1;
        hold1   <= DATA1;
        hold2   <= DATA2;
        hold_pd <= PD;
      end else if (load) pend <= 1'b0;
    end
  assign D1 = sh1[FRAME_W-1];
  assign D2 = sh2[FRAME_W-1];
endmodule

// File: tb/tb_da2_serial_tx.sv
// tb_da2_serial_tx: directed frame checks on a DIV=2 and a DIV=1 transmitter
module tb_da2_serial_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] start = 2'b00;
  logic [11:0] data1 = '0, data2 = '0;
  logic [1:0] pd = 2'b00;
  logic [1:0] sclk, nsync, d1, d2, busy, done;
  int n_vec = 0, n_bad = 0, cyc = 0;
  typedef struct {
    int id;
    logic [15:0] f1, f2;
    int nb, low, cyc;
    logic busy;
  } frm_t;
  frm_t fq[$];
  logic [15:0] w1[2], w2[2];
  int nb[2], low[2], hi[2], gap[2];
  logic ps[2];

  always #5 clk = ~clk;

  da2_serial_tx #(.DIV(2)) u_dut0 (
    .CLOCK(clk), .RESET(rst_n), .START(start[0]), .DATA1(data1), .DATA2(data2), .PD(pd),
    .SCLK(sclk[0]), .nSYNC(nsync[0]), .D1(d1[0]), .D2(d2[0]), .BUSY(busy[0]), .DONE(done[0])
  );
  da2_serial_tx #(.DIV(1)) u_dut1 (
    .CLOCK(clk), .RESET(rst_n), .START(start[1]), .DATA1(data1), .DATA2(data2), .PD(pd),
    .SCLK(sclk[1]), .nSYNC(nsync[1]), .D1(d1[1]), .D2(d2[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  // receiver model: grab D on each SCLK fall inside nSYNC low, log a frame on every DONE
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        nb[i] <= 0;
        low[i] <= 0;
        hi[i] <= 0;
        ps[i] <= 1'b1;
      end else begin
        if (done[i]) fq.push_back('{i, w1[i], w2[i], nb[i], low[i], cyc + 1, busy[i]});
        nb[i] <= (done[i] ? 0 : nb[i]) + int'(ps[i] && !sclk[i] && !nsync[i]);
        low[i] <= (done[i] ? 0 : low[i]) + int'(!nsync[i]);
        hi[i] <= nsync[i] ? hi[i] + 1 : 0;
        if (!nsync[i] && hi[i] > 0) gap[i] <= hi[i];
        if (ps[i] && !sclk[i] && !nsync[i]) begin
          w1[i] <= {w1[i][14:0], d1[i]};
          w2[i] <= {w2[i][14:0], d2[i]};
        end
        ps[i] <= sclk[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle START; acc returns the index of the first frame cycle (the one after the accept edge)
  task automatic send(input int i, input logic [11:0] a, input logic [11:0] b, input logic [1:0] p,
                      output int acc);
    start[i] = 1'b1;
    data1 = a;
    data2 = b;
    pd = p;
    step(1);
    start[i] = 1'b0;
    acc = cyc + 1;
  endtask

  task automatic get(input string tag, input int i, input logic [15:0] e1, input logic [15:0] e2,
                     input int acc, output int dcyc);
    frm_t f;
    int k = 0;
    int div = (i == 0) ? 2 : 1;
    dcyc = 0;
    while (fq.size() == 0 && k < 400) begin
      step(1);
      k++;
    end
    check({tag, ".avail"}, fq.size() != 0, 1);
    if (fq.size() == 0) return;
    f = fq.pop_front();
    dcyc = f.cyc;
    check({tag, ".dut"}, f.id, i);
    check({tag, ".d1"}, f.f1, e1);
    check({tag, ".d2"}, f.f2, e2);
    check({tag, ".bits"}, f.nb, 16);
    check({tag, ".sync_low"}, f.low, 32 * div);
    check({tag, ".done_lat"}, f.cyc - acc, 34 * div);
    check({tag, ".busy_at_done"}, f.busy, 0);
  endtask

  initial begin
    int acc, acc2, dc, dc2;
    rst_n = 1'b0;
    #3;
    check("rst.sclk", sclk[0], 1);
    check("rst.nsync", nsync[0], 1);
    check("rst.d", {d1[0], d2[0]}, 0);
    check("rst.busy", busy[0], 0);
    check("rst.done", done[0], 0);
    step(3);
    rst_n = 1'b1;
    step(2);

    send(0, 12'hA5C, 12'h3F0, 2'b00, acc);
    data1 = 12'h000;
    check("t1.nsync_c1", nsync[0], 0);
    check("t1.sclk_c1", sclk[0], 1);
    check("t1.busy_c1", busy[0], 1);
    get("t1", 0, 16'h0A5C, 16'h03F0, acc, dc);
    step(3);

    send(0, 12'hFFF, 12'h000, 2'b11, acc);
    get("t2", 0, 16'h3FFF, 16'h3000, acc, dc);
    send(1, 12'hFFF, 12'h000, 2'b11, acc);
    get("t2div1", 1, 16'h3FFF, 16'h3000, acc, dc);
    step(3);

    send(0, 12'h456, 12'h789, 2'b00, acc);
    step(18);
    send(0, 12'h123, 12'h0AA, 2'b00, acc2);
    data1 = 12'hEEE;
    data2 = 12'hEEE;
    get("t3a", 0, 16'h0456, 16'h0789, acc, dc);
    get("t3b", 0, 16'h0123, 16'h00AA, dc, dc2);
    check("t3.gap", gap[0], 4);
    step(3);

    send(0, 12'h111, 12'h222, 2'b10, acc);
    step(9);
    send(0, 12'h001, 12'h000, 2'b00, acc2);
    step(9);
    send(0, 12'h002, 12'h000, 2'b00, acc2);
    step(9);
    send(0, 12'h003, 12'h333, 2'b00, acc2);
    get("t4a", 0, 16'h2111, 16'h2222, acc, dc);
    get("t4b", 0, 16'h0003, 16'h0333, dc, dc2);
    step(200);
    check("t4.no_third", fq.size(), 0);
    check("t4.idle_busy", busy[0], 0);

    send(0, 12'hFFF, 12'hFFF, 2'b11, acc);
    step(30);
    check("t5.pre_nsync", nsync[0], 0);
    check("t5.pre_d1", d1[0], 1);
    check("t5.pre_sclk", sclk[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5.nsync", nsync[0], 1);
    check("t5.sclk", sclk[0], 1);
    check("t5.d", {d1[0], d2[0]}, 0);
    check("t5.busy", busy[0], 0);
    step(3);
    rst_n = 1'b1;
    step(80);
    check("t5.no_done", fq.size(), 0);
    send(0, 12'h0F0, 12'hF0F, 2'b01, acc);
    get("t5r", 0, 16'h10F0, 16'h1F0F, acc, dc);
    step(3);

    send(0, 12'h5A3, 12'hC3C, 2'b01, acc);
    for (int k = 0; k < 66; k++) begin
      data1 = 12'($urandom);
      data2 = 12'($urandom);
      pd = 2'($urandom);
      step(1);
    end
    get("t6", 0, 16'h15A3, 16'h1C3C, acc, dc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
